// File: rtl/upbus_arb.sv
// upbus_arb: round-robin arbiter sharing one single-beat register bus among NREQ masters.
// Optional upack timeout is compiled in with `define UPBUS_TOUT_EN.
module upbus_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned CPUW = 8,
  parameter int unsigned ADRW = 8,
  parameter int unsigned TOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      rnw,
  input  logic [NREQ*ADRW-1:0] req_adr,
  input  logic [NREQ*CPUW-1:0] req_wdat,
  output logic [NREQ-1:0]      ack,
  output logic [CPUW-1:0]      rdat,
  output logic                 err,
  output logic [NREQ-1:0]      gnt,
  output logic                 upen,
  output logic                 upws,
  output logic                 uprs,
  output logic [ADRW-1:0]      upadr,
  output logic [CPUW-1:0]      updi,
  input  logic [CPUW-1:0]      updo,
  input  logic                 upack
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SUMW = IDXW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic [IDXW-1:0]   r_last;
  logic [IDXW-1:0]   r_win;
  logic [CPUW-1:0]   r_rdat;
  logic [CPUW-1:0]   r_updi;
  logic [ADRW-1:0]   r_upadr;
  logic              r_upen;
  logic              r_upws;
  logic              r_uprs;

  logic [2*NREQ-1:0] w_req2;
  logic [NREQ-1:0]   w_rot;
  logic [SUMW-1:0]   w_shift;
  logic [SUMW-1:0]   w_sum;
  logic [IDXW-1:0]   w_off;
  logic [IDXW-1:0]   w_win;
  logic              w_rnw;
  logic [ADRW-1:0]   w_adr;
  logic [CPUW-1:0]   w_wdat;
  logic              w_tout;

  // Rotate requests so the index after the last winner sits at bit 0, then take the lowest set bit.
  always_comb begin
    w_req2  = {req, req};
    w_shift = SUMW'(r_last) + SUMW'(1);
    w_rot   = NREQ'(w_req2 >> w_shift);
    w_off   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDXW'(i);
    end
    w_sum = w_shift + SUMW'(w_off);
    w_win = (w_sum >= SUMW'(NREQ)) ? IDXW'(w_sum - SUMW'(NREQ)) : IDXW'(w_sum);
  end

  always_comb begin
    w_rnw  = 1'b0;
    w_adr  = '0;
    w_wdat = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_win == IDXW'(i)) begin
        w_rnw  = rnw[i];
        w_adr  = req_adr[i*ADRW +: ADRW];
        w_wdat = req_wdat[i*CPUW +: CPUW];
      end
    end
  end

`ifdef UPBUS_TOUT_EN
  localparam int unsigned CNTW = $clog2(TOUT + 1);

  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            r_err;

  assign w_cnt_nxt = r_cnt + CNTW'(1);
  assign w_tout    = (w_cnt_nxt == CNTW'(TOUT));

  // Counts ACC cycles without upack; held at zero outside ACC so it is clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_ACC) && !upack && w_tout;
      if (r_state == S_ACC) r_cnt <= w_cnt_nxt;
      else                  r_cnt <= '0;
    end
  end

  assign err = r_err;
`else
  assign w_tout = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_rdat  <= '0;
      r_upen  <= 1'b0;
      r_upws  <= 1'b0;
      r_uprs  <= 1'b0;
      r_upadr <= '0;
      r_updi  <= '0;
      r_win   <= '0;
      r_last  <= IDXW'(NREQ - 1);
    end else begin
      r_ack  <= '0;
      r_rdat <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_win   <= w_win;
            r_upadr <= w_adr;
            r_updi  <= w_wdat;
            r_upen  <= 1'b1;
            r_upws  <= !w_rnw;
            r_uprs  <= w_rnw;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          // A real upack wins over a timeout landing on the same edge.
          if (upack || w_tout) begin
            r_ack   <= r_gnt;
            r_rdat  <= upack ? (r_uprs ? updo : '0) : '1;
            r_gnt   <= '0;
            r_upen  <= 1'b0;
            r_upws  <= 1'b0;
            r_uprs  <= 1'b0;
            r_upadr <= '0;
            r_updi  <= '0;
            r_last  <= r_win;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack   = r_ack;
  assign rdat  = r_rdat;
  assign gnt   = r_gnt;
  assign upen  = r_upen;
  assign upws  = r_upws;
  assign uprs  = r_uprs;
  assign upadr = r_upadr;
  assign updi  = r_updi;

endmodule

// File: tb/tb_upbus_arb.sv
// tb_upbus_arb: vector table, hand sequences and randomized traffic against a queue-free arbitration model.
module tb_upbus_arb;

  localparam int unsigned NREQ = 3;
  localparam int unsigned CPUW = 8;
  localparam int unsigned ADRW = 8;
  localparam int unsigned TOUT = 15;

  logic                 clk      = 1'b0;
  logic                 rst_n    = 1'b0;
  logic [NREQ-1:0]      req      = '0;
  logic [NREQ-1:0]      rnw      = '0;
  logic [NREQ*ADRW-1:0] req_adr  = '0;
  logic [NREQ*CPUW-1:0] req_wdat = '0;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      gnt;
  logic [CPUW-1:0]      rdat;
  logic [CPUW-1:0]      updi;
  logic [CPUW-1:0]      updo;
  logic [ADRW-1:0]      upadr;
  logic                 err;
  logic                 upen;
  logic                 upws;
  logic                 uprs;
  logic                 upack;
  logic [33:0]          outs;

  logic slv_en    = 1'b1;
  logic force_ack = 1'b0;
  logic do_init   = 1'b1;
  int   wait_n    = 0;
  int   acc_cnt   = 0;
  logic [CPUW-1:0] smem [256];
  logic [CPUW-1:0] mm   [256];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int             idx;
    logic           rw;
    logic [7:0]     adr;
    logic [7:0]     wd;
    int             wt;
    logic [7:0]     exp_rd;
    int             exp_lat;
  } vec_t;
  vec_t vt [7];

  int   nacks;
  int   ack_c [4];
  logic [NREQ-1:0] ack_v [4];
  logic [CPUW-1:0] ack_d [4];
  int   m_last, exp_w, gcyc, skip, done_cnt;
  logic in_txn, abort, cur_rw;
  logic [7:0] cur_adr, cur_wd;

  always #5 clk = ~clk;

  upbus_arb #(.NREQ(NREQ), .CPUW(CPUW), .ADRW(ADRW), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rnw(rnw), .req_adr(req_adr), .req_wdat(req_wdat),
    .ack(ack), .rdat(rdat), .err(err), .gnt(gnt), .upen(upen), .upws(upws), .uprs(uprs),
    .upadr(upadr), .updi(updi), .updo(updo), .upack(upack)
  );

  assign outs = {ack, rdat, err, gnt, upen, upws, uprs, upadr, updi};

  function automatic logic [CPUW-1:0] init_val(input int a);
    return CPUW'(a) ^ 8'h1E;
  endfunction

  // Register-bank slave with a programmable number of wait states.
  always @(posedge clk) begin
    acc_cnt <= upen ? acc_cnt + 1 : 0;
    if (do_init) begin
      for (int a = 0; a < 256; a++) smem[a] <= init_val(a);
    end else if (upen && upws && upack) begin
      smem[upadr] <= updi;
    end
  end
  assign upack = force_ack | (slv_en & upen & (acc_cnt >= wait_n));
  assign updo  = (upack && uprs) ? smem[upadr] : '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (r[(last + k) % int'(NREQ)]) return (last + k) % int'(NREQ);
    end
    return -1;
  endfunction

  task automatic new_txn(input int i);
    rnw[i] = 1'($urandom_range(0, 1));
    req_adr[i*ADRW +: ADRW]  = ADRW'($urandom_range(0, 15));
    req_wdat[i*CPUW +: CPUW] = CPUW'($urandom);
    req[i] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One isolated transaction: strobe stability, strobe count, ack latency and one-cycle result.
  task automatic single(input int idx, input logic rw, input logic [7:0] adr, input logic [7:0] wd,
                        input int wt, input logic [7:0] exp_rd, input logic exp_err, input int exp_lat);
    int   n;
    int   strobes;
    logic got;
    wait_n = wt;
    rnw[idx] = rw;
    req_adr[idx*ADRW +: ADRW]  = adr;
    req_wdat[idx*CPUW +: CPUW] = wd;
    req[idx] = 1'b1;
    n = 0; strobes = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (ack != '0) begin
        got = 1'b1;
      end else if (upen) begin
        strobes++;
        chk("strobe_adr", upadr, adr);
        chk("strobe_dat", updi, wd);
        chk("strobe_ws", upws, !rw);
        chk("strobe_rs", uprs, rw);
        chk("strobe_gnt", gnt, 1 << idx);
      end
    end
    req[idx] = 1'b0;
    chk("ack_seen", got, 1);
    chk("ack_latency", n, exp_lat);
    chk("strobe_cycles", strobes, exp_lat - 1);
    chk("ack_vec", ack, 1 << idx);
    chk("ack_rdat", rdat, exp_rd);
    chk("ack_err", err, exp_err);
    chk("done_bus_idle", {gnt, upen, upws, uprs}, 0);
    @(negedge clk);
    chk("after_ack_clear", {ack, rdat, err, upen}, 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 1'b0, 8'h10, 8'hA5, 0, 8'h00, 2};
    vt[1] = '{1, 1'b1, 8'h22, 8'h00, 0, 8'h3C, 2};
    vt[2] = '{0, 1'b1, 8'h10, 8'h00, 2, 8'hA5, 4};
    vt[3] = '{2, 1'b0, 8'h33, 8'h5A, 5, 8'h00, 7};
    vt[4] = '{2, 1'b1, 8'h33, 8'h00, 1, 8'h5A, 3};
    vt[5] = '{1, 1'b0, 8'hFF, 8'hC3, 0, 8'h00, 2};
    vt[6] = '{1, 1'b1, 8'hFF, 8'h00, 3, 8'hC3, 5};

    // Reset state and idle behaviour, including stray upack.
    @(negedge clk);
    chk("reset_outs", outs, 0);
    do_init = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs, 0);
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_upack_ignored", outs, 0);
    end
    force_ack = 1'b0;

    // Contention: two reads held continuously.
    wait_n = 0;
    rnw = 3'b011;
    req_adr[0*ADRW +: ADRW] = 8'h40;
    req_adr[1*ADRW +: ADRW] = 8'h41;
    req = 3'b011;
    nacks = 0;
    for (int c = 1; c <= 40 && nacks < 4; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        ack_v[nacks] = ack;
        ack_c[nacks] = c;
        ack_d[nacks] = rdat;
        nacks++;
      end
    end
    req = '0;
    chk("cont_count", nacks, 4);
    for (int k = 0; k < nacks; k++) begin
      chk("cont_order", ack_v[k], (k % 2 == 0) ? 1 : 2);
      chk("cont_rdat", ack_d[k], (k % 2 == 0) ? 8'h5E : 8'h5F);
      if (k > 0) chk("cont_spacing", ack_c[k] - ack_c[k-1], 3);
    end
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      single(vt[v].idx, vt[v].rw, vt[v].adr, vt[v].wd, vt[v].wt, vt[v].exp_rd, 1'b0, vt[v].exp_lat);
    end

    // Randomized traffic against the round-robin model.
    do_reset();
    for (int a = 0; a < 256; a++) mm[a] = init_val(a);
    m_last = int'(NREQ) - 1;
    in_txn = 1'b0; abort = 1'b0; done_cnt = 0; exp_w = -1; gcyc = 0;
    cur_rw = 1'b0; cur_adr = '0; cur_wd = '0;
    for (int cyc = 0; cyc < 2500 && !abort; cyc++) begin
      @(negedge clk);
      skip = -1;
      if (!in_txn) begin
        chk("rnd_idle_ack", ack, 0);
        if (gnt != '0) begin
          exp_w = pick(req, m_last);
          chk("rnd_gnt", gnt, (exp_w < 0) ? 0 : (1 << exp_w));
          if (exp_w >= 0) begin
            cur_rw  = rnw[exp_w];
            cur_adr = req_adr[exp_w*ADRW +: ADRW];
            cur_wd  = req_wdat[exp_w*CPUW +: CPUW];
            chk("rnd_strobes", {upen, upws, uprs}, {1'b1, !cur_rw, cur_rw});
            chk("rnd_adr", upadr, cur_adr);
            chk("rnd_wdat", updi, cur_wd);
            in_txn = 1'b1;
            gcyc   = cyc;
            wait_n = int'($urandom_range(0, 3));
          end
        end else begin
          chk("rnd_idle_bus", {upen, upws, uprs}, 0);
        end
      end else if (ack != '0) begin
        chk("rnd_ack", ack, 1 << exp_w);
        chk("rnd_rdat", rdat, cur_rw ? mm[cur_adr] : 8'h00);
        chk("rnd_err", err, 0);
        chk("rnd_done_idle", {gnt, upen}, 0);
        chk("rnd_latency", cyc - gcyc, wait_n + 1);
        if (!cur_rw) mm[cur_adr] = cur_wd;
        m_last = exp_w;
        in_txn = 1'b0;
        done_cnt++;
        skip = exp_w;
        if ($urandom_range(0, 1) == 0) new_txn(exp_w);
        else req[exp_w] = 1'b0;
      end else begin
        chk("rnd_hold", {gnt, upen, upadr}, {3'(1 << exp_w), 1'b1, cur_adr});
        if (cyc - gcyc > 20) begin
          checks++;
          failures++;
          $display("FAIL rnd_stall waited=%0d cycles required<=20", cyc - gcyc);
          abort = 1'b1;
        end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (i == skip) continue;
        if (in_txn && i == exp_w) begin
          if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) new_txn(i);
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    chk("rnd_progress", done_cnt > 100, 1);
    req = '0;
    do_reset();

`ifdef UPBUS_TOUT_EN
    slv_en = 1'b0;
    single(0, 1'b0, 8'h50, 8'h77, 0, 8'hFF, 1'b1, int'(TOUT) + 1);
    slv_en = 1'b1;
    single(1, 1'b1, 8'h51, 8'h00, 0, 8'h4F, 1'b0, 2);
`endif

    // Stalled write from requester 1 after requester 0 last completed, then reset mid-ACC.
    single(0, 1'b1, 8'h41, 8'h00, 0, 8'h5F, 1'b0, 2);
    slv_en = 1'b0;
    rnw[1] = 1'b0;
    req_adr[1*ADRW +: ADRW]  = 8'h60;
    req_wdat[1*CPUW +: CPUW] = 8'h12;
    req[1] = 1'b1;
`ifdef UPBUS_TOUT_EN
    repeat (5) @(negedge clk);
`else
    repeat (100) @(negedge clk);
`endif
    chk("stall_bus", {gnt, upen, upws, uprs, upadr, updi}, {3'b010, 1'b1, 1'b1, 1'b0, 8'h60, 8'h12});
    chk("stall_no_ack", ack, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", outs, 0);
    req    = '0;
    slv_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    rnw = 3'b011;
    req_adr[0*ADRW +: ADRW] = 8'h40;
    req_adr[1*ADRW +: ADRW] = 8'h41;
    req = 3'b011;
    @(negedge clk);
    chk("post_reset_gnt", gnt, 3'b001);
    chk("post_reset_no_ack", ack, 0);
    @(negedge clk);
    chk("post_reset_ack", ack, 3'b001);
    chk("post_reset_rdat", rdat, 8'h5E);
    req = '0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
